// File: rtl/mfp_eic_ack_sequencer.sv
// mfp_eic_ack_sequencer
//
// Sits between the EIC core and the MIPSfpga+ CPU EIC port. It latches the
// core's highest-priority request and holds it stable toward the CPU until
// SI_IAck. After the acknowledge it can clear the core flag by writing the
// EIFRC register through the core write port. The AHB register path also
// uses that port. A bus write always wins, and the clear write waits until
// the port is free.
//
// Ports:
//   CLK, RESET         clock and synchronous active-high reset
//   core_interrupt     EIC_Interrupt from core (0 = none, n = channel n-1)
//   core_vector        EIC_Vector from core
//   SI_IAck            CPU interrupt acknowledge pulse
//   bus_write_*        AHB-side register write request
//   write_*            merged write port toward the core (combinational)
//   EIC_Interrupt/Vector  registered request presented to the CPU
//   busy               high whenever the sequencer is not IDLE
//   timeout            one-cycle pulse when a request goes unacknowledged

module mfp_eic_ack_sequencer #(
   parameter int                    ADDR_WIDTH  = 5,
   parameter logic [ADDR_WIDTH-1:0] REG_EIFRC_0 = 5'h8,
   parameter logic [ADDR_WIDTH-1:0] REG_EIFRC_1 = 5'h9,
   parameter logic [ADDR_WIDTH-1:0] REG_NONE    = 5'h1f,
   parameter int                    ACK_TIMEOUT = 1024,
   parameter bit                    AUTO_CLEAR  = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [7:0]            core_interrupt,
   input  logic [5:0]            core_vector,
   input  logic                  SI_IAck,
   input  logic [ADDR_WIDTH-1:0] bus_write_addr,
   input  logic [31:0]           bus_write_data,
   input  logic                  bus_write_enable,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [31:0]           write_data,
   output logic                  write_enable,
   output logic [7:0]            EIC_Interrupt,
   output logic [5:0]            EIC_Vector,
   output logic                  busy,
   output logic                  timeout
);

   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESENT,
      S_CLEAR,
      S_SETTLE,
      S_WAIT_DROP,
      S_GAP
   } state_t;

   state_t          state_q,   state_d;
   logic [7:0]      int_q,     int_d;      // request shown to the CPU
   logic [5:0]      vec_q,     vec_d;
   logic [7:0]      n_q,       n_d;        // acknowledged request, kept for clear/drop
   logic [TW-1:0]   timer_q,   timer_d;
   logic            timeout_q, timeout_d;

   // NOTE: every always_comb output gets a default first, so no path can leave
   // a signal unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      int_d     = int_q;
      vec_d     = vec_q;
      n_d       = n_q;
      timer_d   = '0;
      timeout_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (core_interrupt != 8'd0) begin
               int_d   = core_interrupt;
               vec_d   = core_vector;
               state_d = S_PRESENT;
            end
         end

         S_PRESENT: begin
            timer_d = timer_q + TW'(1);
            // The acknowledge takes priority over a simultaneous drop or timeout.
            if (SI_IAck) begin
               n_d     = int_q;
               int_d   = '0;
               vec_d   = '0;
               state_d = AUTO_CLEAR ? S_CLEAR : S_WAIT_DROP;
            end else if (core_interrupt == 8'd0) begin
               int_d   = '0;
               vec_d   = '0;
               state_d = S_IDLE;
            end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               int_d     = '0;
               vec_d     = '0;
               state_d   = S_GAP;
            end
         end

         // The clear write goes out in any cycle the bus leaves the port free.
         S_CLEAR:     if (!bus_write_enable) state_d = S_SETTLE;

         // This state gives the core flag one cycle to update, so the cleared
         // channel is not presented again.
         S_SETTLE:    state_d = S_IDLE;

         S_WAIT_DROP: if (core_interrupt != n_q) state_d = S_IDLE;

         S_GAP:       state_d = S_IDLE;

         default:     state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         int_q     <= '0;
         vec_q     <= '0;
         n_q       <= '0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         int_q     <= int_d;
         vec_q     <= vec_d;
         n_q       <= n_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   // Clear word. The low five bits of (n-1) give the bit index for both banks:
   // n-1 for channels 1..32 and n-33 for channels 33..64.
   logic [4:0] clr_shift;
   assign clr_shift = n_q[4:0] - 5'd1;

   always_comb begin
      write_enable = 1'b0;
      write_addr   = REG_NONE;
      write_data   = '0;
      if (bus_write_enable) begin
         write_enable = 1'b1;
         write_addr   = bus_write_addr;
         write_data   = bus_write_data;
      end else if (state_q == S_CLEAR) begin
         write_enable = 1'b1;
         write_addr   = (n_q <= 8'd32) ? REG_EIFRC_0 : REG_EIFRC_1;
         write_data   = 32'd1 << clr_shift;
      end
   end

   assign EIC_Interrupt = int_q;
   assign EIC_Vector    = vec_q;
   assign busy          = (state_q != S_IDLE);
   assign timeout       = timeout_q;

endmodule

// File: doc/mfp_eic_ack_sequencer.md
Name: mfp_eic_ack_sequencer

Overview:
Sits between the EIC core and the MIPSfpga+ CPU EIC port. It latches the core's highest-priority request and holds it stable toward the CPU until SI_IAck. It then auto-clears the acknowledged flag by issuing a write to the core's EIFRC register, sharing the core write port with the AHB register path. Bus writes always win; the clear write is deferred until the port is free.

Parameters:
ADDR_WIDTH, 5, width of core register address (matches `EIC_ADDR_WIDTH)
REG_EIFRC_0, 5'h8, core address of flag-clear register, channels 0..31
REG_EIFRC_1, 5'h9, core address of flag-clear register, channels 32..63
REG_NONE, 5'h1f, address driven when no write is issued
ACK_TIMEOUT, 1024, max cycles a request is presented without SI_IAck
AUTO_CLEAR, 1, 1 = hardware clears flag after ack; 0 = wait for software clear

Ports:
CLK  in  1  clock
RESET  in  1  synchronous reset, active-high
core_interrupt  in  8  EIC_Interrupt from core (0 = none, n = channel n-1)
core_vector  in  6  EIC_Vector from core
SI_IAck  in  1  CPU interrupt acknowledge pulse
bus_write_addr  in  ADDR_WIDTH  AHB-side register write address
bus_write_data  in  32  AHB-side write data
bus_write_enable  in  1  AHB-side write strobe
write_addr  out  ADDR_WIDTH  to core write port
write_data  out  32  to core write port
write_enable  out  1  to core write port
EIC_Interrupt  out  8  to CPU; stable while presented
EIC_Vector  out  6  to CPU
busy  out  1  high in any state other than IDLE
timeout  out  1  one-cycle pulse on ack timeout

Behaviour:
- One clock CLK; synchronous, active-high reset RESET. Reset gives state IDLE, EIC_Interrupt=0, EIC_Vector=0, write_enable=0, write_addr=REG_NONE, write_data=0, busy=0, timeout=0, timer=0. Reset mid-operation abandons any pending clear with no write issued.
- Write port (combinational): bus_write_enable=1 passes bus_* through. Else, in CLEAR: write_enable=1, write_addr and write_data = clear word. Else: write_enable=0, addr REG_NONE, data 0.
- Clear word for latched n (1..64): n<=32 -> REG_EIFRC_0, data=1<<(n-1); else REG_EIFRC_1, data=1<<(n-33).
- FSM states (registered outputs):
  - IDLE: if core_interrupt!=0, latch it and core_vector into EIC_Interrupt/EIC_Vector, timer=0, go PRESENT. First CPU-visible request appears one cycle after core_interrupt rises.
  - PRESENT: latched value held stable, no re-sampling. Timer increments.
    - SI_IAck=1 -> capture n, drive EIC_Interrupt=0. Go CLEAR if AUTO_CLEAR=1, else WAIT_DROP.
    - Else core_interrupt==0 (software cleared it) -> outputs 0, go IDLE.
    - Else timer==ACK_TIMEOUT-1 -> timeout pulse, outputs 0, go GAP.
    - SI_IAck takes priority over a simultaneous drop or timeout.
  - CLEAR: issue write when bus_write_enable=0, then go SETTLE. If bus busy, stay; deferral is unbounded.
  - SETTLE: one cycle for the core flag to update, then IDLE. Prevents re-presenting the cleared channel.
  - WAIT_DROP: stay until core_interrupt!=captured n, then IDLE.
  - GAP: one cycle with outputs 0, then IDLE. Re-samples, so a higher-priority request can be presented.
- SI_IAck outside PRESENT is ignored.
- Outputs are 0 in CLEAR, SETTLE, WAIT_DROP and GAP.

Test Plan:
- core_interrupt=5 at cycle 0; SI_IAck at cycle 4 -> EIC_Interrupt=5 cycles 1..4, 0 from cycle 5; write_enable=1, write_addr=REG_EIFRC_0, write_data=32'h10 at cycle 5; busy low at cycle 7.
- core_interrupt=40, acked; bus_write_enable=1 for 3 cycles from the ack-cycle+1 -> bus writes pass through unchanged; clear write REG_EIFRC_1, data 32'h80 issued on the 4th cycle.
- core_interrupt=3 presented; core_interrupt drops to 0 before ack -> EIC_Interrupt=0 next cycle, no clear write, state IDLE.
- ACK_TIMEOUT=8, core_interrupt=7 held, no ack -> timeout pulse after 8 presented cycles, one 0 cycle, then 7 re-presented.
- AUTO_CLEAR=0, core_interrupt=2 acked -> no write issued; stays busy until core_interrupt changes to 9; then 9 presented.
- RESET asserted in CLEAR while bus busy -> all outputs reset values next cycle, no clear write ever issued.
